// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
//   E-stage <-> multiply/divide unit bundle.
//   master : E stage / hazard side (drives MDOp, Start, Req, A, B)
//   slave  : mult_div_unit        (drives Busy, HI, LO)
//   Signals:
//     MDOp  [2:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//     Start        launch pulse for MDOp 1-4
//     Req          flush of the E-stage instruction this cycle
//     A, B  [31:0] forwarded rs / rt operands
//     Busy         operation in flight
//     HI, LO[31:0] architectural HI/LO registers
// ----------------------------------------------------------------------------
interface mult_div_unit_if;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDOp, Start, Req, A, B, input Busy, HI, LO);
  modport slave  (input MDOp, Start, Req, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   E-stage multiply/divide unit. Holds HI/LO, accepts mult/multu/div/divu
//   (multi-cycle, modelled as a countdown) and mthi/mtlo (single edge).
//   The result is computed at the Start edge, parked in tmp_hi/tmp_lo and
//   committed to HI/LO on the edge where Busy falls.
//
//   Parameters:
//     MULT_CYCLES  Busy cycles for mult/multu (>= 1)
//     DIV_CYCLES   Busy cycles for div/divu   (>= 1)
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    mult_div_unit_if.slave (MDOp, Start, Req, A, B -> Busy, HI, LO)
//
//   Build option:
//     MDU_DIV0_KEEP_EN  defined   : divide by zero runs DIV_CYCLES but leaves
//                                   HI/LO unchanged.
//                       undefined : divide by zero gives LO=0xFFFFFFFF, HI=A.
// ----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // State is implied by the countdown: IDLE when counter==0, RUN otherwise.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [CNT_W-1:0] counter;
  logic             state;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      tmp_hi, tmp_lo;
  logic             tmp_wr;

  // Datapath
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        is_signed_div, b_zero;
  logic [31:0] a_mag, b_mag, dvd, dvs, uq, ur, quot, rem;
  logic        start_op;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic [CNT_W-1:0] res_cycles;

  assign state    = (counter != '0) ? ST_RUN : ST_IDLE;
  assign bus.Busy = (state == ST_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  assign start_op = bus.Start && !bus.Req &&
                    (bus.MDOp == OP_MULT || bus.MDOp == OP_MULTU ||
                     bus.MDOp == OP_DIV  || bus.MDOp == OP_DIVU);

  // NOTE: every variable written here is given a default first so no latch is inferred.
  always_comb begin
    a_sx   = {{32{bus.A[31]}}, bus.A};
    b_sx   = {{32{bus.B[31]}}, bus.B};
    prod_s = a_sx * b_sx;   // low 64 bits of the extended product are the signed result
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed division is done on magnitudes through the one unsigned divider.
    // 0x80000000 / 0xFFFFFFFF then falls out as quotient 0x80000000, rem 0.
    is_signed_div = (bus.MDOp == OP_DIV);
    b_zero        = (bus.B == 32'd0);
    a_mag = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    b_mag = bus.B[31] ? (32'd0 - bus.B) : bus.B;
    dvd   = is_signed_div ? a_mag : bus.A;
    dvs   = is_signed_div ? b_mag : bus.B;
    if (dvs == 32'd0) dvs = 32'd1;   // divider never sees zero; div0 handled below
    uq = dvd / dvs;
    ur = dvd % dvs;
    if (is_signed_div) begin
      quot = (bus.A[31] ^ bus.B[31]) ? (32'd0 - uq) : uq;
      rem  = bus.A[31] ? (32'd0 - ur) : ur;
    end else begin
      quot = uq;
      rem  = ur;
    end

    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_wr     = 1'b1;
    res_cycles = MULT_LOAD;
    case (bus.MDOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        res_cycles = DIV_LOAD;
        if (b_zero) begin
`ifdef MDU_DIV0_KEEP_EN
          res_wr = 1'b0;
`else
          res_hi = bus.A;
          res_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pending result is reset too, so an aborted op can never leak into HI/LO.
      counter <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      tmp_hi  <= 32'd0;
      tmp_lo  <= 32'd0;
      tmp_wr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_op) begin
            tmp_hi  <= res_hi;
            tmp_lo  <= res_lo;
            tmp_wr  <= res_wr;
            counter <= res_cycles;
          end else if (!bus.Req && bus.MDOp == OP_MTHI) begin
            hi_q <= bus.A;
          end else if (!bus.Req && bus.MDOp == OP_MTLO) begin
            lo_q <= bus.A;
          end
        end
        default: begin
          // RUN: Start/mthi/mtlo and Req are all ignored; the op just counts down.
          if (counter == CNT_ONE) begin
            if (tmp_wr) begin
              hi_q <= tmp_hi;
              lo_q <= tmp_lo;
            end
            counter <= '0;
          end else begin
            counter <= counter - CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit (MULT_CYCLES=5, DIV_CYCLES=10).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   Every task starts and ends just after a falling edge.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] op, input logic start, input logic req,
                       input logic [31:0] a, input logic [31:0] b);
    bus.MDOp  = op;
    bus.Start = start;
    bus.Req   = req;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic idle();
    drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Launch an op, count Busy cycles (bounded), check cycle count and result.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int n;
    hi0 = bus.HI;
    lo0 = bus.LO;
    drive(op, 1'b1, 1'b0, a, b);
    @(posedge clk); #1 idle();
    n = 0;
    @(negedge clk);
    while (bus.Busy === 1'b1 && n < 50) begin
      n++;
      if (n == 1) begin
        checks++;
        if (bus.HI !== hi0 || bus.LO !== lo0) begin
          errors++;
          $display("FAIL %s_early: HI/LO=%h/%h while busy, expected %h/%h", name, bus.HI, bus.LO, hi0, lo0);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, n, exp_n);
    end
    checks++;
    if (bus.HI !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h expected %h", name, bus.HI, exp_hi);
    end
    checks++;
    if (bus.LO !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h expected %h", name, bus.LO, exp_lo);
    end
  endtask

  // Load HI and LO with mthi/mtlo on consecutive edges.
  task automatic set_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
    drive(3'd5, 1'b0, 1'b0, h, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.HI !== h || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_mthi: HI=%h Busy=%b expected HI=%h Busy=0", name, bus.HI, bus.Busy, h);
    end
    drive(3'd6, 1'b0, 1'b0, l, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (bus.HI !== h || bus.LO !== l || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_mtlo: HI/LO=%h/%h Busy=%b expected %h/%h Busy=0", name, bus.HI, bus.LO, bus.Busy, h, l);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.Busy);
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.HI, bus.LO);
    end
  endtask

  task automatic test_mult();
    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'd2, MC, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_div();
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000);
    run_op("div_negdivisor", 3'd3, 32'd7, 32'hFFFF_FFFE, DC, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14);
  endtask

  task automatic test_mthi_mtlo();
    set_hilo("mtx", 32'h1234_5678, 32'h9ABC_DEF0);
  endtask

  // Start (multu 1x1) and mthi arriving while busy must be ignored.
  task automatic test_start_during_busy();
    int n;
    drive(3'd1, 1'b1, 1'b0, 32'd7, 32'd6);
    @(posedge clk); #1 idle();
    @(negedge clk);
    n = 1;
    drive(3'd2, 1'b1, 1'b0, 32'd1, 32'd1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    if (bus.Busy === 1'b1) n++;
    drive(3'd5, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);
    @(posedge clk); #1 idle();
    @(negedge clk);
    while (bus.Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== MC) begin
      errors++;
      $display("FAIL busy_ignore_cycles: got %0d expected %0d", n, MC);
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
      errors++;
      $display("FAIL busy_ignore_result: got %h/%h expected 00000000/0000002a", bus.HI, bus.LO);
    end
  endtask

  task automatic test_req();
    int n;
    bit busy_seen;
    set_hilo("req_pre", 32'hAAAA_0000, 32'h0000_BBBB);
    // Flushed mult 5x5: nothing happens.
    drive(3'd1, 1'b1, 1'b1, 32'd5, 32'd5);
    @(posedge clk); #1 idle();
    busy_seen = 1'b0;
    repeat (MC + 2) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL req_start_busy: got Busy=1 expected 0");
    end
    checks++;
    if (bus.HI !== 32'hAAAA_0000 || bus.LO !== 32'h0000_BBBB) begin
      errors++;
      $display("FAIL req_start_hilo: got %h/%h expected aaaa0000/0000bbbb", bus.HI, bus.LO);
    end
    // Flushed mthi: ignored.
    drive(3'd5, 1'b0, 1'b1, 32'h0000_FFFF, 32'd0);
    @(negedge clk);
    idle();
    checks++;
    if (bus.HI !== 32'hAAAA_0000) begin
      errors++;
      $display("FAIL req_mthi: got %h expected aaaa0000", bus.HI);
    end
    // Req during RUN does not abort: multu 3x4.
    drive(3'd2, 1'b1, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1 idle();
    bus.Req = 1'b1;
    @(posedge clk); #1 bus.Req = 1'b0;
    @(negedge clk);
    n = 2;
    while (bus.Busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== MC + 1 || bus.HI !== 32'd0 || bus.LO !== 32'd12) begin
      errors++;
      $display("FAIL req_in_run: cycles=%0d HI/LO=%h/%h expected cycles=%0d 00000000/0000000c", n - 1, bus.HI, bus.LO, MC);
    end
  endtask

  // Reset on Busy cycle 3 of a div aborts it.
  task automatic test_reset_mid();
    bit busy_seen;
    set_hilo("rst_pre", 32'h5555_5555, 32'h6666_6666);
    drive(3'd3, 1'b1, 1'b0, 32'd100, 32'd3);
    @(posedge clk); #1 idle();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: Busy=%b HI/LO=%h/%h expected 0 00000000/00000000", bus.Busy, bus.HI, bus.LO);
    end
    busy_seen = 1'b0;
    repeat (DC + 2) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0) busy_seen = 1'b1;
    end
    checks++;
    if (busy_seen || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_late: busy_seen=%b HI/LO=%h/%h expected 0 00000000/00000000", busy_seen, bus.HI, bus.LO);
    end
  endtask

  task automatic test_div0();
    set_hilo("div0_pre", 32'h1111_1111, 32'h2222_2222);
`ifdef MDU_DIV0_KEEP_EN
    run_op("divu_zero", 3'd4, 32'd100, 32'd0, DC, 32'h1111_1111, 32'h2222_2222);
    run_op("div_zero", 3'd3, 32'hFFFF_FFFB, 32'd0, DC, 32'h1111_1111, 32'h2222_2222);
`else
    run_op("divu_zero", 3'd4, 32'd100, 32'd0, DC, 32'd100, 32'hFFFF_FFFF);
    run_op("div_zero", 3'd3, 32'hFFFF_FFFB, 32'd0, DC, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`endif
  endtask

  // Ops issued on the very cycle Busy falls.
  task automatic test_back_to_back();
    run_op("b2b_mult", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'd0, 32'd1);
    run_op("b2b_div", 3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, DC, 32'hFFFF_FFFF, 32'd3);
    run_op("b2b_multu", 3'd2, 32'h0001_0000, 32'h0001_0000, MC, 32'd1, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_start_during_busy();
    test_req();
    test_reset_mid();
    test_div0();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit for the pipelined MIPS core. It drives the Start/Busy handshake that the hazard controller consumes to stall F/D.
- Accepts mult/multu/div/divu/mthi/mtlo from E, holds the HI/LO architectural registers, and runs a multi-cycle countdown per operation.
- HI/LO feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, Busy cycles for div/divu (≥1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- MDOp  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- Start  input  1  E-stage pulse; meaningful only with MDOp 1-4
- Req  input  1  exception/interrupt flush of E-stage instruction this cycle
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- Busy  output  1  operation in flight; hazard controller stalls on (Start|Busy)
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset (sampled at posedge): HI=0, LO=0, Busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO keep no partial result.
- States: IDLE (counter==0), RUN (counter!=0). Busy = (counter!=0), registered-derived with no combinational path from Start.
- IDLE→RUN: at posedge with Start=1, MDOp∈{1..4}, Req=0:
  - compute and latch the 64-bit result into internal tmpHI/tmpLO;
  - counter ← MULT_CYCLES for mult/multu, DIV_CYCLES for div/divu.
- RUN: counter decrements every posedge. At the posedge where counter==1: HI←tmpHI, LO←tmpLO, counter←0.
  - Busy is therefore high exactly N cycles after the Start edge.
  - New HI/LO become visible in the same cycle Busy falls.
- Start while Busy=1: ignored, with no effect on counter or result. The hazard controller never issues it; the bench checks it anyway.
- mthi (5) / mtlo (6) with Req=0 and Busy=0: HI←A or LO←A at the next posedge, zero latency, Busy stays 0. Ignored while Busy=1.
- Req=1: any Start/mthi/mtlo in that cycle is discarded. An operation already in RUN completes normally.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}.
  - multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: see Optional Feature. Never X; no exception raised.
- MDOp 0/7 or Start=0: no state change.

Optional Feature:
- Macro: MDU_DIV0_KEEP_EN
- Defined: div/divu with B==0 still runs DIV_CYCLES Busy cycles, but HI/LO are left unchanged at completion.
- Undefined: divide by zero writes LO=0xFFFFFFFF, HI=A (div and divu alike).

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (-2), B=3 → Busy high for exactly 5 cycles after the Start edge; when Busy falls, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 → Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO updated one edge each, Busy never asserts. A second Start (multu 1×1) during Busy is ignored, so the first result stands.
- Start=1 with Req=1 (mult 5×5) → Busy stays 0, HI/LO unchanged. Reset asserted on Busy cycle 3 of a div → next cycle Busy=0, HI=LO=0.
- divu A=100, B=0 → without the macro: LO=0xFFFFFFFF, HI=100. With MDU_DIV0_KEEP_EN: HI/LO equal their pre-op values after 10 Busy cycles.
